// File: rtl/vbr_pkg.sv
// Shared types and helpers for the banked vector RAM.
package vbr_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  function automatic int unsigned lane_bits(input int unsigned lanes);
    return $clog2(lanes);
  endfunction

  function automatic int unsigned rd_lat(input int unsigned out_reg);
    return 1 + out_reg;
  endfunction

endpackage

// File: rtl/lane_bram.sv
// One lane of the banked RAM: simple dual-port, registered read-first read port.
module lane_bram #(
  parameter int unsigned WORD_W = 32,
  parameter int unsigned ROW_AW = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ROW_AW-1:0] waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic              re,
  input  logic [ROW_AW-1:0] raddr,
  output logic [WORD_W-1:0] rdata
);

  localparam int unsigned ROWS = 1 << ROW_AW;

  logic [WORD_W-1:0] r_mem [ROWS];
  logic [WORD_W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (we) r_mem[waddr] <= wdata;
  end

  // Read samples the array before this edge's write lands: read-first.
  always_ff @(posedge clk) begin
    if (rst)     r_rdata <= '0;
    else if (re) r_rdata <= r_mem[raddr];
  end

  assign rdata = r_rdata;

endmodule

// File: rtl/vector_bank_ram.sv
// Banked RAM with a full-row read port, word/row writes and a built-in clear engine.
module vector_bank_ram
  import vbr_pkg::*;
#(
  parameter  int unsigned WORD_W  = 32,
  parameter  int unsigned ADDR_W  = 10,
  parameter  int unsigned LANES   = 16,
  parameter  int unsigned OUT_REG = 1,
  localparam int unsigned LANE_B  = lane_bits(LANES),
  localparam int unsigned ROW_AW  = ADDR_W - LANE_B
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clr_start,
  output logic                      busy,
  input  logic                      wr_en,
  input  logic                      wr_vec,
  input  logic [ADDR_W-1:0]         wr_addr,
  input  logic [WORD_W*LANES-1:0]   wr_data,
  output logic                      wr_ready,
  input  logic                      rd_en,
  input  logic [ROW_AW-1:0]         rd_row,
  output logic                      rd_ready,
  output logic                      rd_valid,
  output logic [WORD_W*LANES-1:0]   rd_data
);

  localparam int unsigned ROWS = 1 << ROW_AW;
  localparam int unsigned LAT  = rd_lat(OUT_REG);

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic [ROW_AW-1:0]         r_clr_cnt;
  logic                      w_busy;
  logic                      w_clr_we;
  logic                      w_wr_acc;
  logic                      w_rd_acc;
  logic [ROW_AW-1:0]         w_wr_row;
  logic [LANE_B-1:0]         w_wr_lane;
  logic [ROW_AW-1:0]         w_waddr;
  logic [LANES-1:0]          w_we;
  logic [WORD_W*LANES-1:0]   w_bank_rdata;
  logic [LAT-1:0]            r_vld;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (clr_start) w_state_nxt = CLEAR;
      CLEAR:   if (r_clr_cnt == ROW_AW'(ROWS - 1)) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // A reset edge must not land the clear write of the row in progress.
  always_comb begin
    w_busy   = (r_state == CLEAR);
    w_clr_we = w_busy && !rst;
  end

  always_ff @(posedge clk) begin
    if (rst)                                  r_clr_cnt <= '0;
    else if (w_busy && r_clr_cnt == ROW_AW'(ROWS - 1)) r_clr_cnt <= '0;
    else if (w_busy)                          r_clr_cnt <= r_clr_cnt + ROW_AW'(1);
  end

  assign w_wr_acc  = wr_en && !w_busy;
  assign w_rd_acc  = rd_en && !w_busy;
  assign w_wr_row  = wr_addr[ADDR_W-1:LANE_B];
  assign w_wr_lane = wr_addr[LANE_B-1:0];
  assign w_waddr   = w_busy ? r_clr_cnt : w_wr_row;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [WORD_W-1:0] w_wdata;

    assign w_we[i] = w_clr_we || (w_wr_acc && (wr_vec || w_wr_lane == LANE_B'(i)));
    assign w_wdata = w_busy ? '0 :
                     (wr_vec ? wr_data[i*WORD_W +: WORD_W] : wr_data[WORD_W-1:0]);

    lane_bram #(
      .WORD_W (WORD_W),
      .ROW_AW (ROW_AW)
    ) u_bank (
      .clk   (clk),
      .rst   (rst),
      .we    (w_we[i]),
      .waddr (w_waddr),
      .wdata (w_wdata),
      .re    (w_rd_acc),
      .raddr (rd_row),
      .rdata (w_bank_rdata[i*WORD_W +: WORD_W])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld <= '0;
    end else begin
      r_vld[0] <= w_rd_acc;
      for (int k = 1; k < LAT; k++) r_vld[k] <= r_vld[k-1];
    end
  end

  if (OUT_REG != 0) begin : g_oreg
    logic [WORD_W*LANES-1:0] r_rd_data;

    always_ff @(posedge clk) begin
      if (rst)           r_rd_data <= '0;
      else if (r_vld[0]) r_rd_data <= w_bank_rdata;
    end

    assign rd_data = r_rd_data;
  end else begin : g_noreg
    assign rd_data = w_bank_rdata;
  end

  assign busy     = w_busy;
  assign wr_ready = !w_busy;
  assign rd_ready = !w_busy;
  assign rd_valid = r_vld[LAT-1];

endmodule

// File: tb/tb_vector_bank_ram.sv
// Scoreboard bench: OUT_REG=1 and OUT_REG=0 instances share stimulus and a row model.
module tb_vector_bank_ram;

  typedef struct {
    logic [31:0] d;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, clr_start, wr_en, wr_vec, rd_en;
  logic [5:0]  wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  rd_row;

  logic        busy1, wr_ready1, rd_ready1, rd_valid1;
  logic [31:0] rd_data1;
  logic        busy0, wr_ready0, rd_ready0, rd_valid0;
  logic [31:0] rd_data0;

  logic [31:0] m [16];
  exp_t        q1[$];
  exp_t        q0[$];
  logic [31:0] last1, last0;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  bit          mon_en = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  vector_bank_ram #(.WORD_W(8), .ADDR_W(6), .LANES(4), .OUT_REG(1)) u_dut1 (
    .clk(clk), .rst(rst), .clr_start(clr_start), .busy(busy1),
    .wr_en(wr_en), .wr_vec(wr_vec), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ready(wr_ready1), .rd_en(rd_en), .rd_row(rd_row), .rd_ready(rd_ready1),
    .rd_valid(rd_valid1), .rd_data(rd_data1)
  );

  vector_bank_ram #(.WORD_W(8), .ADDR_W(6), .LANES(4), .OUT_REG(0)) u_dut0 (
    .clk(clk), .rst(rst), .clr_start(clr_start), .busy(busy0),
    .wr_en(wr_en), .wr_vec(wr_vec), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ready(wr_ready0), .rd_en(rd_en), .rd_row(rd_row), .rd_ready(rd_ready0),
    .rd_valid(rd_valid0), .rd_data(rd_data0)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp_v, cyc);
    end
  endtask

  // One cycle of stimulus; the model is updated as the DUT would accept it.
  task automatic step(input logic we, input logic vec, input logic [5:0] wa,
                      input logic [31:0] wd, input logic re, input logic [3:0] rr,
                      input logic clr, input logic rs);
    logic bz;
    exp_t e;
    bz = busy1;
    wr_en = we; wr_vec = vec; wr_addr = wa; wr_data = wd;
    rd_en = re; rd_row = rr; clr_start = clr; rst = rs;
    if (!rs && !bz) begin
      if (re) begin
        e.d = m[rr];
        e.due = cyc + 2; q1.push_back(e);
        e.due = cyc + 1; q0.push_back(e);
      end
      if (we) begin
        if (vec) m[wa[5:2]] = wd;
        else     m[wa[5:2]][wa[1:0]*8 +: 8] = wd[7:0];
      end
      if (clr) for (int r = 0; r < 16; r++) m[r] = '0;
    end
    @(posedge clk);
    #1;
    wr_en = 1'b0; wr_vec = 1'b0; rd_en = 1'b0; clr_start = 1'b0; rst = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, '0, '0, 0, '0, 0, 0);
  endtask

  task automatic fill(input logic [31:0] v);
    for (int r = 0; r < 16; r++) step(1, 1, 6'(r * 4), v, 0, '0, 0, 0);
  endtask

  task automatic read_all();
    for (int r = 0; r < 16; r++) step(0, 0, '0, '0, 1, 4'(r), 0, 0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    bit   ev;
    if (mon_en) begin
      while (q1.size() > 0 && q1[0].due < cyc) void'(q1.pop_front());
      ev = (q1.size() > 0) && (q1[0].due == cyc);
      chk("rd_valid_oreg1", 64'(rd_valid1), 64'(ev));
      if (ev) begin e = q1.pop_front(); last1 = e.d; end
      chk("rd_data_oreg1", 64'(rd_data1), 64'(last1));

      while (q0.size() > 0 && q0[0].due < cyc) void'(q0.pop_front());
      ev = (q0.size() > 0) && (q0[0].due == cyc);
      chk("rd_valid_oreg0", 64'(rd_valid0), 64'(ev));
      if (ev) begin e = q0.pop_front(); last0 = e.d; end
      chk("rd_data_oreg0", 64'(rd_data0), 64'(last0));
    end
  end

  initial begin
    last1 = '0; last0 = '0;
    wr_en = 1'b0; wr_vec = 1'b0; wr_addr = '0; wr_data = '0;
    rd_en = 1'b0; rd_row = '0; clr_start = 1'b0; rst = 1'b1;
    step(0, 0, '0, '0, 0, '0, 0, 1);
    step(0, 0, '0, '0, 0, '0, 0, 1);
    chk("rst_busy", 64'(busy1), 64'(0));
    chk("rst_rd_valid", 64'(rd_valid1), 64'(0));
    chk("rst_rd_data", 64'(rd_data1), 64'(0));
    chk("rst_rd_data_noreg", 64'(rd_data0), 64'(0));
    chk("rst_ready", 64'({wr_ready1, rd_ready1}), 64'(2'b11));
    mon_en = 1'b1;

    // Known contents everywhere; row 7 left at zero for the collision case.
    for (int r = 0; r < 16; r++)
      step(1, 1, 6'(r * 4), (r == 7) ? 32'h0 : 32'h11111111 * 32'(r), 0, '0, 0, 0);

    // Single-word writes into lanes 1 and 2 of row 1
    step(1, 0, 6'h05, 32'h000000A1, 0, '0, 0, 0);
    step(1, 0, 6'h06, 32'h000000B2, 0, '0, 0, 0);
    step(0, 0, '0, '0, 1, 4'd1, 0, 0);
    idle(3);
    chk("row1_model", 64'(m[1]), 64'(32'h11B2A111));

    // Vector write then back-to-back reads
    step(1, 1, 6'h0C, 32'h44332211, 0, '0, 0, 0);
    step(0, 0, '0, '0, 1, 4'd3, 0, 0);
    step(0, 0, '0, '0, 1, 4'd3, 0, 0);
    step(0, 0, '0, '0, 1, 4'd2, 0, 0);
    idle(3);

    // Same-cycle write/read to row 7 returns old data
    step(1, 1, 6'h1C, 32'hDEADBEEF, 1, 4'd7, 0, 0);
    step(0, 0, '0, '0, 1, 4'd7, 0, 0);
    idle(3);

    // Full clear with a write and a read riding the clr_start cycle
    fill(32'hFFFFFFFF);
    step(1, 1, 6'h00, 32'h5A5A5A5A, 1, 4'd1, 1, 0);
    for (int i = 0; i < 16; i++) begin
      chk("clr_busy", 64'(busy1), 64'(1));
      chk("clr_busy_noreg", 64'(busy0), 64'(1));
      chk("clr_ready", 64'({wr_ready1, rd_ready1}), 64'(0));
      step(1, 1, 6'h08, 32'h12345678, 1, 4'd2, 0, 0);
    end
    chk("clr_done", 64'(busy1), 64'(0));
    idle(2);
    read_all();
    idle(3);

    // Reset in the middle of a clear
    fill(32'hFFFFFFFF);
    step(0, 0, '0, '0, 0, '0, 1, 0);
    idle(5);
    chk("mid_busy", 64'(busy1), 64'(1));
    step(0, 0, '0, '0, 0, '0, 0, 1);
    last1 = '0; last0 = '0;
    chk("mid_rst_busy", 64'(busy1), 64'(0));
    chk("mid_rst_valid", 64'(rd_valid1), 64'(0));
    for (int r = 5; r < 16; r++) m[r] = 32'hFFFFFFFF;
    idle(2);
    read_all();

    idle(4);
    chk("q_drained_oreg1", 64'(q1.size()), 64'(0));
    chk("q_drained_oreg0", 64'(q0.size()), 64'(0));
    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vector_bank_ram.md
Name: vector_bank_ram

Overview:
- Banked on-chip RAM with a LANES-word-wide read port, for feeding vector datapaths one full row per cycle.
- Writes are either single-word (lane selected by low address bits) or full-row vector writes.
- Read and write ports are independent, so a read and a write can complete in the same cycle.
- A built-in clear engine zeroes the whole array without external sequencing.
- Sits between the host/load path and the vector compute pipes.

Parameters:
- WORD_W, 32: bits per word.
- ADDR_W, 10: word address width. ROW_AW = ADDR_W - log2(LANES); ROWS = 2^ROW_AW.
- LANES, 16: words per row. Must be a power of two and at least 2.
- OUT_REG, 1: 0 or 1. Adds an output register stage. Read latency = 1 + OUT_REG.

Ports:
- clk, in, 1: clock; all logic on posedge.
- rst, in, 1: synchronous, active-high reset.
- clr_start, in, 1: request a full-array clear.
- busy, out, 1: clear in progress.
- wr_en, in, 1: write request.
- wr_vec, in, 1: 1 = full-row write; 0 = single-word write.
- wr_addr, in, ADDR_W: word address; only the upper ROW_AW bits are used when wr_vec=1.
- wr_data, in, WORD_W*LANES: lane i at [i*WORD_W +: WORD_W]; single-word writes use lane 0 bits.
- wr_ready, out, 1: equals !busy.
- rd_en, in, 1: read request.
- rd_row, in, ROW_AW: row to read.
- rd_ready, out, 1: equals !busy.
- rd_valid, out, 1: read data valid, one-cycle pulse.
- rd_data, out, WORD_W*LANES: row data, lane 0 at the LSBs.

Behaviour:
- Reset values:
  - busy=0, rd_valid=0, rd_data=0, clear counter=0, state=IDLE.
  - Memory contents are not reset.
- Write accept:
  - A write is accepted when wr_en && wr_ready.
  - Single-word write: row = wr_addr[ADDR_W-1:log2(LANES)], lane = wr_addr[log2(LANES)-1:0]. Only that lane's bank is written.
  - Vector write: all LANES banks are written at the row.
  - Writes take effect at the accepting clock edge.
- Read accept:
  - A read is accepted when rd_en && rd_ready.
  - rd_valid pulses exactly 1+OUT_REG cycles after the accepting edge.
  - rd_data changes only on a rd_valid cycle and holds its value otherwise.
  - Back-to-back reads sustain one row per cycle.
- Read/write collision: a read and a write to the same row in the same cycle return the pre-write data (read-first). Lanes not written are unaffected.
- State machine:
  - IDLE: clr_start=1 moves to CLEAR. busy=1 from the next cycle.
  - CLEAR: writes zero to all lanes of row = counter, one row per cycle, counter 0 to ROWS-1. After row ROWS-1, returns to IDLE and busy=0 on the following cycle. CLEAR lasts exactly ROWS cycles.
  - clr_start while busy is ignored.
- Simultaneous events:
  - A write or read presented in the same cycle as clr_start (busy still 0) is accepted; the subsequent clear overwrites that write.
  - wr_en/rd_en while busy are dropped. No queuing, no error flag.
  - Reads accepted before CLEAR still deliver rd_valid with the pre-clear data.
- Reset mid-CLEAR: returns to IDLE immediately and the array is left partially cleared. Reset also cancels in-flight rd_valid pulses.

Decomposition:
- Shared package vbr_pkg:
  - lane-bit function/constant (clog2 of LANES);
  - state encoding IDLE/CLEAR;
  - read-latency constant expression.
- One sub-module, lane_bram:
  - single-lane simple dual-port RAM, WORD_W x ROWS;
  - one write port (we, waddr, wdata) and one registered read port (re, raddr, rdata), read-first;
  - instantiated LANES times.
- The top level holds the write decode, clear FSM/counter, read-valid shift pipeline and optional output register.

Test Plan:
Configuration for all scenarios: WORD_W=8, ADDR_W=6, LANES=4 (ROWS=16), OUT_REG=1.
1. Single-word writes: addr 0x05 data 0xA1, then 0x06 data 0xB2; read row 1 -> rd_valid 2 cycles later with lane1=0xA1, lane2=0xB2, lanes 0/3 unchanged.
2. Vector write: row 3 data 0x44332211; consecutive reads of rows 3,3,2 -> three consecutive rd_valid pulses, first = 0x44332211.
3. Collision: row 7 holds 0x0; vector write 0xDEADBEEF and read row 7 in the same cycle -> returns 0x0; a read the next cycle -> returns 0xDEADBEEF.
4. Clear: fill all rows with 0xFF; pulse clr_start -> busy=1 for 16 cycles; wr_en asserted during busy is dropped; after busy falls, every row reads 0x00000000.
5. Reset mid-clear: pulse rst at clear cycle 5 -> busy=0 next cycle; rows 0-4 read 0, rows 5-15 keep 0xFF; rd_valid stays 0 with no pending reads.
6. OUT_REG=0 rerun of scenario 2 -> latency 1 cycle, same data.
